// File: rtl/range_check_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// range_check_scheduler_pkg
// Shared types and helpers for the range-check scheduler slice.
//   sched_state_t         : scheduler FSM states (IDLE, CLEAR, RUN, REPORT)
//   DEFAULT_NUM_CHECKERS  : default size of the checker bank
//   DEFAULT_COUNT_WIDTH   : default width of the accumulated result
//   RUN_CYCLES_WIDTH      : width of the optional RUN-duration counter
//   sat_add()             : saturating add for accumulators up to 64 bits wide
// -----------------------------------------------------------------------------
package range_check_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } sched_state_t;

  localparam int DEFAULT_NUM_CHECKERS = 4;
  localparam int DEFAULT_COUNT_WIDTH  = 32;
  localparam int RUN_CYCLES_WIDTH     = 32;

  // Adds two zero-extended operands and clamps the sum at the all-ones value
  // of a 'width'-bit accumulator. The 65-bit intermediate keeps the carry
  // visible even for a full 64-bit accumulator.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned width);
    logic [64:0] sum;
    logic [64:0] max_val;
    sum     = {1'b0, a} + {1'b0, b};
    max_val = (width >= 64) ? {1'b0, {64{1'b1}}} : ((65'd1 << width) - 65'd1);
    return (sum > max_val) ? max_val[63:0] : sum[63:0];
  endfunction

endpackage

// File: rtl/range_check_scheduler_popcount_sat_acc.sv
// -----------------------------------------------------------------------------
// popcount_sat_acc
// Counts the set bits of i_bits each enabled cycle and adds them into a
// registered accumulator that saturates at all-ones (never wraps).
// Ports:
//   clk       : clock
//   reset     : synchronous, active-high; clears the accumulator
//   i_clear   : synchronous clear (wins over i_enable)
//   i_enable  : add popcount(i_bits) this cycle
//   i_bits    : IN_WIDTH pulse vector to be counted
//   o_count   : current accumulator value
// COUNT_WIDTH must be in 1..64.
// -----------------------------------------------------------------------------
module popcount_sat_acc
  import range_check_scheduler_pkg::*;
#(
  parameter int IN_WIDTH    = 4,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clear,
  input  logic                   i_enable,
  input  logic [IN_WIDTH-1:0]    i_bits,
  output logic [COUNT_WIDTH-1:0] o_count
);

  logic [63:0]            w_popcount;
  logic [COUNT_WIDTH-1:0] w_acc_next;
  logic [COUNT_WIDTH-1:0] r_acc;

  // NOTE: combinational loops accumulate with blocking '=' so each iteration
  // sees the previous partial sum; the default assignment up front keeps the
  // block free of inferred latches.
  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      w_popcount = w_popcount + 64'(i_bits[i]);
    end
  end

  assign w_acc_next = COUNT_WIDTH'(sat_add(64'(r_acc), w_popcount, COUNT_WIDTH));

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
    end else if (i_enable) begin
      r_acc <= w_acc_next;
    end
  end

  assign o_count = r_acc;

endmodule

// File: rtl/range_check_scheduler.sv
// -----------------------------------------------------------------------------
// range_check_scheduler
// Sequences a bank of NUM_CHECKERS range_checker instances: holds them in reset
// while idle, releases them together after a one-cycle CLEAR, sums their jump
// pulses while running, and presents the total on a valid/ack handshake once
// every checker reports done.
// Ports:
//   clk            : clock
//   reset          : synchronous, active-high
//   start          : one-cycle run request, accepted only in IDLE
//   busy           : high from start acceptance until the result is acked
//   checker_reset  : per-checker synchronous reset (registered)
//   checker_jump   : per-checker jump pulses (already gated by done)
//   checker_done   : per-checker sticky done flags
//   result_valid   : result_count is valid; held until result_ack
//   result_ack     : consumer accepts the result
//   result_count   : total jumps counted during the run (saturating)
//   run_cycles     : number of RUN cycles of the last run (only when the
//                    RANGE_SCHED_CYCLE_COUNT_EN macro is defined)
// -----------------------------------------------------------------------------
module range_check_scheduler
  import range_check_scheduler_pkg::*;
#(
  parameter int NUM_CHECKERS = DEFAULT_NUM_CHECKERS,
  parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic [NUM_CHECKERS-1:0] checker_reset,
  input  logic [NUM_CHECKERS-1:0] checker_jump,
  input  logic [NUM_CHECKERS-1:0] checker_done,
  output logic                    result_valid,
  input  logic                    result_ack,
  output logic [COUNT_WIDTH-1:0]  result_count
`ifdef RANGE_SCHED_CYCLE_COUNT_EN
  ,
  output logic [RUN_CYCLES_WIDTH-1:0] run_cycles
`endif
);

  sched_state_t            r_state;
  sched_state_t            w_state_next;
  logic                    r_busy;
  logic                    w_busy_next;
  logic [NUM_CHECKERS-1:0] r_checker_reset;
  logic [NUM_CHECKERS-1:0] w_checker_reset_next;
  logic                    r_result_valid;
  logic                    w_result_valid_next;
  logic [COUNT_WIDTH-1:0]  r_result_count;
  logic [COUNT_WIDTH-1:0]  w_result_count_next;

  logic                    w_acc_clear;
  logic                    w_acc_en;
  logic [COUNT_WIDTH-1:0]  w_acc;
  logic                    w_all_done;

  assign w_all_done = &checker_done;
  // Jumps are only ever counted while the checkers are released.
  assign w_acc_en   = (r_state == RUN);

  popcount_sat_acc #(
    .IN_WIDTH    (NUM_CHECKERS),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_jump_acc (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_acc_clear),
    .i_enable (w_acc_en),
    .i_bits   (checker_jump),
    .o_count  (w_acc)
  );

`ifdef RANGE_SCHED_CYCLE_COUNT_EN
  // Same accumulator fed with a constant 1: counts RUN cycles and freezes on
  // REPORT entry because enable drops there.
  popcount_sat_acc #(
    .IN_WIDTH    (1),
    .COUNT_WIDTH (RUN_CYCLES_WIDTH)
  ) u_cycle_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (r_state == CLEAR),
    .i_enable (w_acc_en),
    .i_bits   (1'b1),
    .o_count  (run_cycles)
  );
`else
  // Cycle counter not built; the scheduler behaves identically otherwise.
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= IDLE;
      r_busy          <= 1'b0;
      r_checker_reset <= '1;
      r_result_valid  <= 1'b0;
      r_result_count  <= '0;
    end else begin
      r_state         <= w_state_next;
      r_busy          <= w_busy_next;
      r_checker_reset <= w_checker_reset_next;
      r_result_valid  <= w_result_valid_next;
      r_result_count  <= w_result_count_next;
    end
  end

  always_comb begin
    w_state_next         = r_state;
    w_busy_next          = r_busy;
    w_checker_reset_next = r_checker_reset;
    w_result_valid_next  = r_result_valid;
    w_result_count_next  = r_result_count;
    w_acc_clear          = 1'b0;

    case (r_state)
      IDLE: begin
        w_checker_reset_next = '1;
        if (start) begin
          w_acc_clear  = 1'b1;
          w_busy_next  = 1'b1;
          w_state_next = CLEAR;
        end
      end
      CLEAR: begin
        // checker_reset is still all ones during this cycle; release takes
        // effect as RUN begins, so every checker sees a full reset edge.
        w_checker_reset_next = '0;
        w_state_next         = RUN;
      end
      RUN: begin
        // A checker's last jump precedes its done flag by a cycle, so the
        // accumulator is already complete when all-done is seen here.
        if (w_all_done) begin
          w_result_valid_next = 1'b1;
          w_result_count_next = w_acc;
          w_state_next        = REPORT;
        end
      end
      REPORT: begin
        if (result_ack && r_result_valid) begin
          w_result_valid_next  = 1'b0;
          w_busy_next          = 1'b0;
          w_checker_reset_next = '1;
          w_state_next         = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign busy          = r_busy;
  assign checker_reset = r_checker_reset;
  assign result_valid  = r_result_valid;
  assign result_count  = r_result_count;

endmodule

// File: tb/tb_range_check_scheduler.sv
// -----------------------------------------------------------------------------
// tb_range_check_scheduler
// Drives two schedulers (32-bit and 4-bit result) from the same stub checker
// bank. Each run pushes the expected totals into a scoreboard when its
// stimulus is planned; the entry is popped when result_valid appears.
// Define RANGE_SCHED_CYCLE_COUNT_EN to also check run_cycles.
// -----------------------------------------------------------------------------
module tb_range_check_scheduler;

  localparam int N = 4;

  typedef int plan_t[N];

  typedef struct {
    logic [31:0] count;
    logic [3:0]  sat_count;
    logic [31:0] cycles;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start;
  logic          result_ack;
  logic [N-1:0]  checker_jump;
  logic [N-1:0]  checker_done;

  logic          busy;
  logic          result_valid;
  logic [N-1:0]  checker_reset;
  logic [31:0]   result_count;

  logic          s_busy;
  logic          s_valid;
  logic [N-1:0]  s_checker_reset;
  logic [3:0]    s_count;

`ifdef RANGE_SCHED_CYCLE_COUNT_EN
  logic [31:0]   run_cycles;
  logic [31:0]   s_run_cycles;
`endif

  range_check_scheduler #(
    .NUM_CHECKERS (N),
    .COUNT_WIDTH  (32)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (busy),
    .checker_reset (checker_reset),
    .checker_jump  (checker_jump),
    .checker_done  (checker_done),
    .result_valid  (result_valid),
    .result_ack    (result_ack),
    .result_count  (result_count)
`ifdef RANGE_SCHED_CYCLE_COUNT_EN
    ,
    .run_cycles    (run_cycles)
`endif
  );

  range_check_scheduler #(
    .NUM_CHECKERS (N),
    .COUNT_WIDTH  (4)
  ) u_dut_sat (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .busy          (s_busy),
    .checker_reset (s_checker_reset),
    .checker_jump  (checker_jump),
    .checker_done  (checker_done),
    .result_valid  (s_valid),
    .result_ack    (result_ack),
    .result_count  (s_count)
`ifdef RANGE_SCHED_CYCLE_COUNT_EN
    ,
    .run_cycles    (s_run_cycles)
`endif
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete run: plan stub behaviour, push expectations, drive start,
  // play the stubs, wait for the result, hold it for 'hold' cycles (optionally
  // poking start), then acknowledge.
  task automatic run_test(input string name, input plan_t njump, input plan_t done_at,
                          input int hold, input bit poke_start);
    exp_t        e;
    int          last;
    int          total;
    int          waited;
    logic [31:0] cap;
    bit          early_valid;
    bit          busy_drop;
    bit          unstable;

    total = 0;
    last  = 0;
    for (int i = 0; i < N; i++) begin
      total += (njump[i] < done_at[i]) ? njump[i] : done_at[i];
      if (done_at[i] > last) last = done_at[i];
    end
    e.count     = 32'(total);
    e.sat_count = (total > 15) ? 4'd15 : 4'(total);
    e.cycles    = 32'(last + 1);
    sb_q.push_back(e);

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({name, "_clear_busy"}, 64'(busy), 64'd1);
    check({name, "_clear_chk_rst"}, 64'(checker_reset), 64'hF);

    early_valid = 1'b0;
    busy_drop   = 1'b0;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      if (k == 0) check({name, "_run_chk_rst"}, 64'(checker_reset), 64'h0);
      if (result_valid || s_valid) early_valid = 1'b1;
      if (!busy) busy_drop = 1'b1;
      for (int i = 0; i < N; i++) begin
        checker_jump[i] = (k < njump[i]) && (k < done_at[i]);
        checker_done[i] = (k >= done_at[i]);
      end
    end

    @(negedge clk);
    checker_jump = '0;
    check({name, "_no_early_valid"}, 64'(early_valid), 64'd0);
    check({name, "_busy_held"}, 64'(busy_drop), 64'd0);
    check({name, "_valid_latency"}, 64'(result_valid), 64'd1);

    waited = 0;
    while (!result_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!result_valid) check({name, "_valid_timeout"}, 64'(result_valid), 64'd1);

    e = sb_q.pop_front();
    check({name, "_count"}, 64'(result_count), 64'(e.count));
    check({name, "_sat_count"}, 64'(s_count), 64'(e.sat_count));
    check({name, "_sat_valid"}, 64'(s_valid), 64'd1);
`ifdef RANGE_SCHED_CYCLE_COUNT_EN
    check({name, "_run_cycles"}, 64'(run_cycles), 64'(e.cycles));
`endif

    cap      = result_count;
    unstable = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!result_valid || result_count !== cap || !busy) unstable = 1'b1;
      start = poke_start && (h == hold / 2);
    end
    start = 1'b0;
    if (hold > 0) check({name, "_hold_stable"}, 64'(unstable), 64'd0);

    result_ack = 1'b1;
    @(negedge clk);
    result_ack   = 1'b0;
    checker_done = '0;
    check({name, "_ack_valid"}, 64'(result_valid), 64'd0);
    check({name, "_ack_busy"}, 64'(busy), 64'd0);
    check({name, "_ack_chk_rst"}, 64'(checker_reset), 64'hF);
    check({name, "_count_retained"}, 64'(result_count), 64'(cap));
    @(negedge clk);
    check({name, "_still_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    result_ack   = 1'b0;
    checker_jump = '0;
    checker_done = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_count", 64'(result_count), 64'd0);
    check("rst_chk_rst", 64'(checker_reset), 64'hF);
    reset = 1'b0;

    // Stray ack while nothing is valid must not disturb the idle scheduler.
    @(negedge clk) result_ack = 1'b1;
    @(negedge clk) result_ack = 1'b0;
    check("idle_ack_valid", 64'(result_valid), 64'd0);
    check("idle_ack_busy", 64'(busy), 64'd0);
    check("idle_chk_rst", 64'(checker_reset), 64'hF);

    run_test("basic",     '{3, 0, 5, 2},  '{3, 0, 5, 2},   2, 1'b0);
    run_test("simul",     '{3, 3, 3, 3},  '{3, 3, 3, 3},   0, 1'b0);
    run_test("stagger",   '{5, 2, 7, 40}, '{5, 10, 20, 40}, 1, 1'b0);
    run_test("handshake", '{1, 2, 3, 4},  '{2, 3, 4, 5},  20, 1'b1);
    run_test("saturate",  '{5, 5, 5, 5},  '{5, 5, 5, 5},   1, 1'b0);

    // Reset in the middle of RUN discards the run.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (4) begin
      @(negedge clk) checker_jump = '1;
    end
    @(negedge clk);
    checker_jump = '0;
    reset        = 1'b1;
    @(negedge clk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_valid", 64'(result_valid), 64'd0);
    check("midrst_chk_rst", 64'(checker_reset), 64'hF);
    check("midrst_count", 64'(result_count), 64'd0);
    check("midrst_sat_chk_rst", 64'(s_checker_reset), 64'hF);
    check("midrst_sat_busy", 64'(s_busy), 64'd0);
    reset = 1'b0;

    run_test("after_rst", '{3, 0, 5, 2}, '{3, 0, 5, 2}, 1, 1'b0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
